// File: rtl/zdos_strobe_if.sv
// zdos_strobe_if: Z80 bus pins, DOS sideband state and the decoded event
// outputs of zdos_strobe, bundled as one interface.
//   master : CPU/board side; drives the bus and sidebands and receives the events
//   slave  : zdos_strobe; samples the bus and sidebands and drives the events
// Signals:
//   za[15:0], zm1_n, zmreq_n, ziorq_n, zrd_n, zwr_n : raw Z80 address and strobes
//   dos, romnram, rom48, in_trdemu                  : current mapping/DOS state
//   dos_turn_on, dos_turn_off, vg_rdwr_fclk, clr_nmi: one-fclk event pulses
//   vg_a[1:0], vg_wr                                : last VG93 access descriptor
interface zdos_strobe_if;
    logic [15:0] za;
    logic        zm1_n;
    logic        zmreq_n;
    logic        ziorq_n;
    logic        zrd_n;
    logic        zwr_n;
    logic        dos;
    logic        romnram;
    logic        rom48;
    logic        in_trdemu;

    logic        dos_turn_on;
    logic        dos_turn_off;
    logic        vg_rdwr_fclk;
    logic [1:0]  vg_a;
    logic        vg_wr;
    logic        clr_nmi;

    modport master (
        output za, zm1_n, zmreq_n, ziorq_n, zrd_n, zwr_n,
        output dos, romnram, rom48, in_trdemu,
        input  dos_turn_on, dos_turn_off, vg_rdwr_fclk, vg_a, vg_wr, clr_nmi
    );

    modport slave (
        input  za, zm1_n, zmreq_n, ziorq_n, zrd_n, zwr_n,
        input  dos, romnram, rom48, in_trdemu,
        output dos_turn_on, dos_turn_off, vg_rdwr_fclk, vg_a, vg_wr, clr_nmi
    );
endinterface

// File: rtl/zdos_strobe.sv
// zdos_strobe: synchronizes Z80 bus strobes, filters them and decodes each bus
// cycle into at most one single-fclk event for the DOS/TR-DOS control block.
// Ports:
//   fclk : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : zdos_strobe_if.slave (Z80 pins + sidebands in, event pulses out)
// Parameters:
//   SYNC_STAGES (1..4) : flop stages on the aligned strobe/address word
//   FILT        (1..7) : consecutive synchronized samples needed to qualify
// Build option:
//   ZDOS_STRICT_ROM48_EN : when defined, dos_turn_on also requires rom48=1
// Latency: a pulse is registered SYNC_STAGES+FILT edges after the first edge
// that samples the raw bus combination.
module zdos_strobe #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT        = 1
) (
    input  logic         fclk,
    input  logic         rst,
    zdos_strobe_if.slave bus
);

    // sync word layout: {za[15:0], m1_n, mreq_n, iorq_n, rd_n, wr_n, valid}
    localparam int unsigned SW = 22;
    localparam logic [SW-1:0] SYNC_RST = {16'h0000, 5'b11111, 1'b0};

    localparam logic [1:0] CLS_NONE  = 2'd0;
    localparam logic [1:0] CLS_FETCH = 2'd1;
    localparam logic [1:0] CLS_IO    = 2'd2;
    localparam logic [1:0] CLS_INTA  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_QUAL = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam bit         FILT_ONE  = (FILT == 1);
    localparam logic [2:0] FILT_LAST = 3'(FILT - 1);

`ifdef ZDOS_STRICT_ROM48_EN
    localparam bit STRICT_ROM48 = 1'b1;
`else
    localparam bit STRICT_ROM48 = 1'b0;
`endif

    logic [SW-1:0] r_sync [SYNC_STAGES];
    logic [SW-1:0] w_raw;
    logic [SW-1:0] w_s;
    logic [15:0]   w_s_za;
    logic          w_s_m1, w_s_mreq, w_s_iorq, w_s_rd, w_s_wr, w_s_vld;
    logic [1:0]    w_cls;

    logic [1:0]    r_state, w_state_nx;
    logic [2:0]    r_cnt, w_cnt_nx;
    logic [1:0]    r_cls, w_cls_nx;
    logic          r_blk, w_blk_nx;
    logic          w_fire;

    logic          w_ev_on, w_ev_off, w_ev_vg, w_ev_clr, w_vg_port;
    logic          r_ev_on, r_ev_off, r_ev_vg, r_ev_clr;
    logic [1:0]    r_ev_vga;
    logic          r_ev_vgwr;

    logic          r_dos_turn_on, r_dos_turn_off, r_vg_rdwr, r_clr_nmi;
    logic [1:0]    r_vg_a;
    logic          r_vg_wr;

    // Aligned strobe + address synchronizer; valid marks data captured after reset
    assign w_raw = {bus.za, bus.zm1_n, bus.zmreq_n, bus.ziorq_n,
                    bus.zrd_n, bus.zwr_n, 1'b1};

    always_ff @(posedge fclk) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= SYNC_RST;
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_s_za   = w_s[21:6];
    assign w_s_m1   = w_s[5];
    assign w_s_mreq = w_s[4];
    assign w_s_iorq = w_s[3];
    assign w_s_rd   = w_s[2];
    assign w_s_wr   = w_s[1];
    assign w_s_vld  = w_s[0];

    // Bus cycle classification
    always_comb begin
        w_cls = CLS_NONE;
        if (!w_s_m1 && !w_s_mreq && !w_s_rd)
            w_cls = CLS_FETCH;
        else if (!w_s_iorq && w_s_m1 && (!w_s_rd || !w_s_wr))
            w_cls = CLS_IO;
        else if (!w_s_m1 && !w_s_iorq)
            w_cls = CLS_INTA;
    end

    // Event decode from the synchronized word and current sidebands
    assign w_vg_port = (w_s_za[7] == 1'b0) && (w_s_za[4:0] == 5'h1F);
    assign w_ev_on   = (w_cls == CLS_FETCH) && (w_s_za[15:8] == 8'h3D) &&
                       bus.romnram && !bus.dos && (bus.rom48 || !STRICT_ROM48);
    assign w_ev_off  = (w_cls == CLS_FETCH) && (w_s_za[15:14] != 2'b00) && bus.dos;
    assign w_ev_vg   = (w_cls == CLS_IO) && bus.dos && w_vg_port;
    assign w_ev_clr  = (w_cls == CLS_IO) && !w_s_wr && (w_s_za[7:0] == 8'hBE) &&
                       bus.in_trdemu;

    // Qualification FSM state register
    always_ff @(posedge fclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_cls   <= CLS_NONE;
            r_blk   <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cls   <= w_cls_nx;
            r_blk   <= w_blk_nx;
        end
    end

    // Next state; r_blk keeps a bus cycle that straddled reset from qualifying
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cls_nx   = r_cls;
        w_blk_nx   = r_blk;
        w_fire     = 1'b0;

        if (w_s_vld && (w_cls == CLS_NONE)) w_blk_nx = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!r_blk) begin
                    if ((w_cls == CLS_FETCH) || (w_cls == CLS_IO)) begin
                        w_cls_nx = w_cls;
                        w_cnt_nx = 3'd1;
                        if (FILT_ONE) begin
                            w_fire     = 1'b1;
                            w_state_nx = ST_HOLD;
                        end else begin
                            w_state_nx = ST_QUAL;
                        end
                    end else if (w_cls == CLS_INTA) begin
                        w_state_nx = ST_HOLD;
                    end
                end
            end
            ST_QUAL: begin
                if (w_cls != r_cls) begin
                    w_state_nx = ST_IDLE;
                end else if (r_cnt == FILT_LAST) begin
                    // this sample completes the filter window
                    w_fire     = 1'b1;
                    w_state_nx = ST_HOLD;
                end else begin
                    w_cnt_nx = r_cnt + 3'd1;
                end
            end
            ST_HOLD: begin
                if (w_cls == CLS_NONE) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Event stage then output stage; vg_a/vg_wr update with the vg pulse
    always_ff @(posedge fclk) begin
        if (rst) begin
            r_ev_on        <= 1'b0;
            r_ev_off       <= 1'b0;
            r_ev_vg        <= 1'b0;
            r_ev_clr       <= 1'b0;
            r_ev_vga       <= 2'd0;
            r_ev_vgwr      <= 1'b0;
            r_dos_turn_on  <= 1'b0;
            r_dos_turn_off <= 1'b0;
            r_vg_rdwr      <= 1'b0;
            r_clr_nmi      <= 1'b0;
            r_vg_a         <= 2'd0;
            r_vg_wr        <= 1'b0;
        end else begin
            r_ev_on        <= w_fire && w_ev_on;
            r_ev_off       <= w_fire && w_ev_off;
            r_ev_vg        <= w_fire && w_ev_vg;
            r_ev_clr       <= w_fire && w_ev_clr;
            r_ev_vga       <= w_s_za[6:5];
            r_ev_vgwr      <= !w_s_wr;
            r_dos_turn_on  <= r_ev_on;
            r_dos_turn_off <= r_ev_off;
            r_vg_rdwr      <= r_ev_vg;
            r_clr_nmi      <= r_ev_clr;
            if (r_ev_vg) begin
                r_vg_a  <= r_ev_vga;
                r_vg_wr <= r_ev_vgwr;
            end
        end
    end

    assign bus.dos_turn_on  = r_dos_turn_on;
    assign bus.dos_turn_off = r_dos_turn_off;
    assign bus.vg_rdwr_fclk = r_vg_rdwr;
    assign bus.clr_nmi      = r_clr_nmi;
    assign bus.vg_a         = r_vg_a;
    assign bus.vg_wr        = r_vg_wr;

endmodule

// File: tb/tb_zdos_strobe.sv
// tb_zdos_strobe: scoreboard bench for zdos_strobe. Two instances share one
// stimulus stream: defaults (FILT=1) and FILT=3. Expected events come from a
// transaction-level model (cycle class + address rules + fixed latency).
module tb_zdos_strobe;

    localparam int S  = 2;
    localparam int F0 = 1;
    localparam int F1 = 3;

`ifdef ZDOS_STRICT_ROM48_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    // kinds: 1 dos_turn_on, 2 dos_turn_off, 3 vg access, 4 clr_nmi
    typedef struct {
        int          id;
        int unsigned t;
        int          kind;
        logic [1:0]  a;
        logic        wr;
    } exp_t;

    logic fclk = 1'b0;
    logic rst  = 1'b1;
    always #5 fclk = ~fclk;

    int unsigned cyc = 0;
    always @(posedge fclk) cyc <= cyc + 1;

    zdos_strobe_if bus0();
    zdos_strobe_if bus1();

    zdos_strobe u_dut0 (.fclk(fclk), .rst(rst), .bus(bus0));
    zdos_strobe #(.SYNC_STAGES(S), .FILT(F1)) u_dut1 (.fclk(fclk), .rst(rst), .bus(bus1));

    exp_t       qe[$];
    logic [1:0] exp_va [2];
    logic       exp_vw [2];
    int         n_cmp = 0;
    int         n_err = 0;
    logic       cur_dos, cur_rn, cur_r48, cur_trd;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // strobes packed as {m1_n, mreq_n, iorq_n, rd_n, wr_n}
    task automatic drive(input logic [15:0] a, input logic [4:0] s);
        bus0.za = a; bus1.za = a;
        {bus0.zm1_n, bus0.zmreq_n, bus0.ziorq_n, bus0.zrd_n, bus0.zwr_n} = s;
        {bus1.zm1_n, bus1.zmreq_n, bus1.ziorq_n, bus1.zrd_n, bus1.zwr_n} = s;
    endtask

    task automatic set_side(input logic d, input logic rn, input logic r48, input logic trd);
        cur_dos = d; cur_rn = rn; cur_r48 = r48; cur_trd = trd;
        bus0.dos = d; bus0.romnram = rn; bus0.rom48 = r48; bus0.in_trdemu = trd;
        bus1.dos = d; bus1.romnram = rn; bus1.rom48 = r48; bus1.in_trdemu = trd;
    endtask

    // typ: 0 M1 fetch, 1 IO read, 2 IO write, 3 interrupt ack, 4 plain mem read
    function automatic int model_kind(input int typ, input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        if (typ == 0) begin
            if (a[15:8] == 8'h3D && cur_rn && !cur_dos && (cur_r48 || !STRICT)) return 1;
            if (a[15:14] != 2'b00 && cur_dos) return 2;
        end else if (typ == 1 || typ == 2) begin
            if (cur_dos && (lo == 8'h1F || lo == 8'h3F || lo == 8'h5F || lo == 8'h7F)) return 3;
            if (typ == 2 && lo == 8'hBE && cur_trd) return 4;
        end
        return 0;
    endfunction

    // One bus cycle held len clocks; called and returns on a falling edge
    task automatic txn(input int typ, input logic [15:0] a, input int len, input int gap);
        int          k;
        int          g;
        int unsigned t0;
        logic [4:0]  s;
        k  = model_kind(typ, a);
        t0 = cyc + 1;
        if (k != 0) begin
            if (len >= F0) qe.push_back('{0, t0 + S + F0, k, a[6:5], typ == 2});
            if (len >= F1) qe.push_back('{1, t0 + S + F1, k, a[6:5], typ == 2});
        end
        case (typ)
            0:       s = 5'b00101;
            1:       s = 5'b11001;
            2:       s = 5'b11010;
            3:       s = 5'b01011;
            default: s = 5'b10101;
        endcase
        drive(a, s);
        repeat (len) @(negedge fclk);
        drive(a, 5'b11111);
        // keep sidebands stable until the slowest instance has decided
        g = (len + gap < 6) ? 6 - len : gap;
        repeat (g) @(negedge fclk);
    endtask

    task automatic mon(input int id, input logic on, input logic off, input logic vg,
                       input logic clr, input logic [1:0] va, input logic vw);
        int   idx[$];
        int   np;
        int   act;
        exp_t e;
        idx = qe.find_first_index(x) with (x.id == id);
        while (idx.size() > 0 && qe[idx[0]].t < cyc) begin
            n_cmp++; n_err++;
            $display("FAIL missed_event dut%0d: got none expected kind %0d at cyc %0d",
                     id, qe[idx[0]].kind, qe[idx[0]].t);
            qe.delete(idx[0]);
            idx = qe.find_first_index(x) with (x.id == id);
        end
        np  = int'(on) + int'(off) + int'(vg) + int'(clr);
        act = on ? 1 : off ? 2 : vg ? 3 : clr ? 4 : 0;
        if (np > 1) begin
            n_cmp++; n_err++;
            $display("FAIL multi_pulse dut%0d: got %0d pulses expected 1 (cyc %0d)", id, np, cyc);
        end
        if (np > 0) begin
            n_cmp++;
            if (idx.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event dut%0d: got kind %0d expected none (cyc %0d)",
                         id, act, cyc);
            end else begin
                e = qe[idx[0]];
                qe.delete(idx[0]);
                if (e.t != cyc || e.kind != act) begin
                    n_err++;
                    $display("FAIL event dut%0d: got kind %0d at cyc %0d expected kind %0d at cyc %0d",
                             id, act, cyc, e.kind, e.t);
                end
                if (e.kind == 3) begin
                    exp_va[id] = e.a;
                    exp_vw[id] = e.wr;
                end
            end
        end
        n_cmp++;
        if (va !== exp_va[id] || vw !== exp_vw[id]) begin
            n_err++;
            $display("FAIL vg_state dut%0d: got a=%0d wr=%0d expected a=%0d wr=%0d (cyc %0d)",
                     id, va, vw, exp_va[id], exp_vw[id], cyc);
        end
    endtask

    // Monitor: independent of stimulus, pops the scoreboard on every pulse
    always @(negedge fclk) begin
        if (!rst) begin
            mon(0, bus0.dos_turn_on, bus0.dos_turn_off, bus0.vg_rdwr_fclk, bus0.clr_nmi,
                bus0.vg_a, bus0.vg_wr);
            mon(1, bus1.dos_turn_on, bus1.dos_turn_off, bus1.vg_rdwr_fclk, bus1.clr_nmi,
                bus1.vg_a, bus1.vg_wr);
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_on0"},  int'(bus0.dos_turn_on),  0);
        chk({tag, "_off0"}, int'(bus0.dos_turn_off), 0);
        chk({tag, "_vg0"},  int'(bus0.vg_rdwr_fclk), 0);
        chk({tag, "_clr0"}, int'(bus0.clr_nmi),      0);
        chk({tag, "_va0"},  int'(bus0.vg_a),         0);
        chk({tag, "_vw0"},  int'(bus0.vg_wr),        0);
        chk({tag, "_on1"},  int'(bus1.dos_turn_on),  0);
        chk({tag, "_va1"},  int'(bus1.vg_a),         0);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom % 6)
            0:       return {8'h3D, 8'($urandom)};
            1:       return 16'h8000 | 16'($urandom);
            2:       return 16'($urandom) & 16'h3FFF;
            3:       return {8'($urandom), 1'b0, 2'($urandom), 5'h1F};
            4:       return {8'($urandom), 8'hBE};
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_va[0] = 2'd0; exp_va[1] = 2'd0;
        exp_vw[0] = 1'b0; exp_vw[1] = 1'b0;
        set_side(1'b0, 1'b1, 1'b1, 1'b0);
        drive(16'h0000, 5'b11111);
        rst = 1'b1;
        repeat (3) @(negedge fclk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        repeat (8) @(negedge fclk);

        // DOS entry at #3D2F, held 6 clocks: one pulse only
        set_side(1'b0, 1'b1, 1'b1, 1'b0);
        txn(0, 16'h3D2F, 6, 3);
        // DOS exit from upper memory, none from ROM area
        set_side(1'b1, 1'b1, 1'b1, 1'b0);
        txn(0, 16'h8000, 3, 2);
        txn(0, 16'h1234, 3, 2);
        // VG93 accesses; dos=0 must leave vg_a/vg_wr alone
        txn(1, 16'h007F, 3, 2);
        txn(2, 16'h003F, 3, 2);
        set_side(1'b0, 1'b1, 1'b1, 1'b0);
        txn(1, 16'h001F, 3, 2);
        chk("vg_a_held0", int'(bus0.vg_a), 1);
        chk("vg_wr_held0", int'(bus0.vg_wr), 1);
        chk("vg_a_held1", int'(bus1.vg_a), 1);
        // #BE release
        set_side(1'b0, 1'b1, 1'b1, 1'b1);
        txn(2, 16'h00BE, 3, 2);
        set_side(1'b0, 1'b1, 1'b1, 1'b0);
        txn(2, 16'h00BE, 3, 2);
        set_side(1'b0, 1'b1, 1'b1, 1'b1);
        txn(1, 16'h00BE, 3, 2);
        // glitch rejection on the FILT=3 instance, then full access, then INTA
        set_side(1'b1, 1'b1, 1'b1, 1'b0);
        txn(1, 16'h001F, 2, 4);
        txn(1, 16'h001F, 3, 2);
        txn(3, 16'h00FF, 4, 2);

        // reset while the #3D00 fetch is being qualified; strobe held afterwards
        set_side(1'b0, 1'b1, 1'b1, 1'b0);
        drive(16'h3D00, 5'b00101);
        repeat (3) @(negedge fclk);
        rst = 1'b1;
        exp_va[0] = 2'd0; exp_va[1] = 2'd0;
        exp_vw[0] = 1'b0; exp_vw[1] = 1'b0;
        repeat (2) @(negedge fclk);
        chk_outputs_zero("midrst");
        rst = 1'b0;
        repeat (8) @(negedge fclk);
        drive(16'h3D00, 5'b11111);
        repeat (6) @(negedge fclk);

        // rom48=0 entry (outcome depends on the strict build option)
        set_side(1'b0, 1'b1, 1'b0, 1'b0);
        txn(0, 16'h3D00, 3, 2);

        for (int i = 0; i < 300; i++) begin
            set_side(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            txn(int'($urandom % 5), pick_addr(), int'($urandom_range(1, 6)),
                int'($urandom_range(1, 3)));
        end

        repeat (12) @(negedge fclk);
        while (qe.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL leftover_event dut%0d: got none expected kind %0d at cyc %0d",
                     qe[0].id, qe[0].kind, qe[0].t);
            qe.delete(0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/zdos_strobe.md
Name: zdos_strobe

Overview:
- Upstream front-end of the DOS/TR-DOS emulation control block.
- Watches Z80 bus strobes and decodes them into single-fclk event pulses:
  - DOS entry and exit requests (dos_turn_on / dos_turn_off).
  - VG93 port accesses (vg_rdwr_fclk plus vg_a / vg_wr).
  - The `out (#BE),a` emulation release (clr_nmi).
- Sits between the CPU pins and the DOS/trdemu state register, and supplies that register's event inputs.

Parameters:
- SYNC_STAGES, 2: flop stages applied to bus strobes and, in a parallel aligned pipeline, to address bits; legal values 1..4.
- FILT, 1: consecutive synchronized samples a strobe combination must stay asserted before it is qualified; legal values 1..7.

Ports:
- fclk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- za  in  16  Z80 address bus
- zm1_n  in  1  Z80 M1, active-low
- zmreq_n  in  1  Z80 MREQ, active-low
- ziorq_n  in  1  Z80 IORQ, active-low
- zrd_n  in  1  Z80 RD, active-low
- zwr_n  in  1  Z80 WR, active-low
- dos  in  1  current DOS state (fed back from the DOS register)
- romnram  in  1  1 = ROM mapped at #0000-#3FFF
- rom48  in  1  1 = 48K BASIC ROM page selected
- in_trdemu  in  1  emulation RAM page currently active
- dos_turn_on  out  1  one-cycle pulse
- dos_turn_off  out  1  one-cycle pulse
- vg_rdwr_fclk  out  1  one-cycle pulse, VG93 port access
- vg_a  out  2  VG register index of the last VG access
- vg_wr  out  1  1 = last VG access was a write
- clr_nmi  out  1  one-cycle pulse

Behaviour:
- Reset (rst=1 at a rising edge):
  - All pulse outputs are 0; vg_a=0; vg_wr=0.
  - Sync pipelines are cleared to inactive (strobes=1, address=0); FSM goes to IDLE.
  - Reset mid-cycle discards any qualification in progress; no pulse is emitted afterwards for that bus cycle.
- Synchronization:
  - Raw strobes and za pass through SYNC_STAGES flops as one aligned word ("s_*" below).
- Cycle classification, from the s_* values:
  - FETCH = !s_m1 & !s_mreq & !s_rd.
  - IO = !s_iorq & s_m1 & (!s_rd | !s_wr).
  - INTA = !s_m1 & !s_iorq.
  - NONE = otherwise.
- FSM states IDLE, QUAL, HOLD; filter counter cnt is 3 bits.
  - IDLE: on FETCH or IO, go to QUAL with cnt=1 and latch the class. On INTA, go to HOLD with no event. Otherwise stay in IDLE.
  - QUAL: if the class is unchanged, increment cnt. When the sampled cnt==FILT, emit the event for that class and go to HOLD.
    - If the class changes or drops to NONE before that, return to IDLE with no event (glitch rejection).
    - With FILT=1 the event fires from IDLE directly: IDLE→HOLD, QUAL is skipped.
  - HOLD: stay until class is NONE, then go to IDLE. This guarantees at most one event per bus cycle.
- Events, decoded from the s_za value at qualification:
  - FETCH, s_za[15:8]==#3D, romnram=1, !dos → dos_turn_on.
  - FETCH, s_za[15:14]!=0, dos=1 → dos_turn_off.
  - IO, dos=1, s_za[7:0] in {#1F,#3F,#5F,#7F}:
    - vg_rdwr_fclk pulses.
    - vg_a ← s_za[6:5] and vg_wr ← !s_wr, both updated on the same edge as the pulse and held until the next VG access.
  - IO write, s_za[7:0]==#BE, in_trdemu=1 → clr_nmi.
  - No other combination produces an output.
- Latency and pulse shape:
  - A pulse is high for exactly one fclk.
  - It is registered high at edge SYNC_STAGES+FILT, counting the first edge that samples the raw combination active as edge 0.
  - Defaults: 3 edges.
- Simultaneous events: none are possible, because the classes are mutually exclusive. dos_turn_on and dos_turn_off are exclusive through dos.

Optional Feature:
- Macro ZDOS_STRICT_ROM48_EN.
- Defined: dos_turn_on additionally requires rom48=1.
- Undefined: rom48 is ignored, and entry at #3Dxx works from any ROM page.

Test Plan:
- Defaults, rom48=1, romnram=1, dos=0; M1 fetch at #3D2F held 6 fclk → dos_turn_on high exactly one cycle, 3 edges after the strobe is sampled. No second pulse while held.
- dos=1; M1 fetch at #8000 → dos_turn_off single pulse. Same fetch at #1234 → no pulse.
- dos=1; IO read #7F → vg_rdwr_fclk pulse, vg_a=3, vg_wr=0. Then IO write #3F → vg_a=1, vg_wr=1. With dos=0 → no pulse, vg_a unchanged.
- in_trdemu=1; IO write #BE → clr_nmi pulse. Same with in_trdemu=0, or as an IO read → nothing.
- FILT=3; a 2-cycle IORQ glitch on #1F → no pulse. A 3-cycle access → one pulse. Interrupt acknowledge (M1+IORQ) → no event.
- rst asserted during QUAL of a #3D00 fetch → outputs 0, no pulse after rst falls while the strobe is still held. With ZDOS_STRICT_ROM48_EN and rom48=0, the #3D00 fetch gives no dos_turn_on.
